// File: rtl/io_ctl_gen.sv
// io_ctl_gen: memory-mapped I/O block for the CPU data bus.
//   - LED register, two-flop synchronised switch inputs
//   - NDIG-digit multiplexed hex seven-segment display
//   - UART 8N1 transmitter fed from a TX FIFO, programmable baud divisor
// Ports:
//   clk_i    system clock (rising edge)
//   rst_ni   asynchronous active-low reset
//   din_i    write data          addr_i  byte address (ADDR[1:0] ignored)
//   we_i     write strobe        rreq_i  read strobe
//   do_o     read data (0 unless rdy_o)   rdy_o  one-cycle acknowledge
//   tx_o     UART serial output, idle high
//   sw_i     raw switches        led_o   LED register
//   ssgd_o   segments {dp,g,f,e,d,c,b,a}, active-low
//   ssgs_o   digit select, one-hot active-low
module io_ctl_gen #(
   parameter int          LED_W        = 8,
   parameter int          SW_W         = 8,
   parameter int          NDIG         = 8,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          BAUD_DIV_RST = 868,
   parameter int          SCAN_DIV     = 50000,
   parameter logic [31:0] BASE         = 32'h8000_0000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [31:0]      din_i,
   input  logic [31:0]      addr_i,
   input  logic             we_i,
   input  logic             rreq_i,
   output logic [31:0]      do_o,
   output logic             rdy_o,
   output logic             tx_o,
   input  logic [SW_W-1:0]  sw_i,
   output logic [LED_W-1:0] led_o,
   output logic [7:0]       ssgd_o,
   output logic [NDIG-1:0]  ssgs_o
);
   localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = PW + 1;
   localparam int SSG_W = 4 * NDIG;
   localparam int DIGW  = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [15:0] DIV_RST = 16'(BAUD_DIV_RST);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   // ---------------- registers ----------------
   logic [LED_W-1:0] led_q;
   logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
   logic [SSG_W-1:0] ssg_q;
   logic [15:0]      div_q;
   logic             ovf_q;
   logic [31:0]      do_q;
   logic             rdy_q;

   // FIFO
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    rd_byte_q;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   // UART
   uart_state_t state_q;
   logic        tx_q;
   logic [15:0] baud_cnt_q, bdiv_q;
   logic [2:0]  bit_idx_q;
   logic [6:0]  sh_q;

   // display
   logic [SCW-1:0]  scan_cnt_q;
   logic [DIGW-1:0] dig_q, dig_d;
   logic [7:0]      ssgd_q;
   logic [NDIG-1:0] ssgs_q;
   logic [3:0]      nib [NDIG];

   // ---------------- address decode ----------------
   logic hit, sel_led, sel_ssg, sel_uart, sel_div, rd_only;
   assign hit      = (addr_i[31:8] == BASE[31:8]);
   assign sel_led  = hit && (addr_i[7:2] == 6'h00);
   assign sel_ssg  = hit && (addr_i[7:2] == 6'h02);
   assign sel_uart = hit && (addr_i[7:2] == 6'h03);
   assign sel_div  = hit && (addr_i[7:2] == 6'h04);
   assign rd_only  = rreq_i && !we_i;

   logic unused_ok;
   assign unused_ok = ^{addr_i[1:0], din_i};

   // ---------------- FIFO control ----------------
   logic full, empty, push_req, pop, push_ok;
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign pop      = (state_q == S_IDLE) && !empty;
   assign push_req = we_i && sel_uart;
   // A push on a full FIFO still fits when the transmitter frees a slot this cycle.
   assign push_ok  = push_req && (!full || pop);

   // ---------------- read mux ----------------
   logic [31:0] rdata_d;
   always_comb begin
      rdata_d = '0;
      if (hit) begin
         case (addr_i[7:2])
            6'h00: rdata_d[LED_W-1:0] = led_q;
            6'h01: rdata_d[SW_W-1:0]  = sw_s2_q;
            6'h02: rdata_d[SSG_W-1:0] = ssg_q;
            6'h03: rdata_d = {ovf_q, 21'b0, full, empty, 8'(count_q)};
            6'h04: rdata_d = {16'b0, div_q};
            default: rdata_d = '0;
         endcase
      end
   end

   // ---------------- bus side and registers ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_q    <= 1'b0;
         do_q     <= '0;
         led_q    <= '0;
         ssg_q    <= '0;
         div_q    <= DIV_RST;
         ovf_q    <= 1'b0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         sw_s1_q <= sw_i;
         sw_s2_q <= sw_s1_q;
         rdy_q   <= we_i || rreq_i;
         do_q    <= rd_only ? rdata_d : '0;
         if (we_i && sel_led) led_q <= din_i[LED_W-1:0];
         if (we_i && sel_ssg) ssg_q <= din_i[SSG_W-1:0];
         if (we_i && sel_div) div_q <= (din_i[15:0] < 16'd2) ? 16'd2 : din_i[15:0];
         if (push_req && full && !pop)  ovf_q <= 1'b1;
         else if (rd_only && sel_uart)  ovf_q <= 1'b0;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage: no reset so it maps onto block RAM; read-before-write on the same slot.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i[7:0];
      if (pop)     rd_byte_q <= mem_q[rd_ptr_q];
   end

   // ---------------- UART transmitter ----------------
   logic baud_end;
   assign baud_end = (baud_cnt_q == bdiv_q - 16'd1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         tx_q       <= 1'b1;
         baud_cnt_q <= '0;
         bdiv_q     <= DIV_RST;
         bit_idx_q  <= '0;
         sh_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (!empty) begin
                  // Divisor is captured here so a change only applies from a start bit.
                  state_q    <= S_START;
                  tx_q       <= 1'b0;
                  baud_cnt_q <= '0;
                  bdiv_q     <= div_q;
               end
            end
            S_START: begin
               if (baud_end) begin
                  state_q    <= S_DATA;
                  tx_q       <= rd_byte_q[0];
                  sh_q       <= rd_byte_q[7:1];
                  bit_idx_q  <= '0;
                  baud_cnt_q <= '0;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud_cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     tx_q      <= sh_q[0];
                     sh_q      <= sh_q >> 1;
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            S_STOP: begin
               if (baud_end) begin
                  state_q    <= S_IDLE;
                  baud_cnt_q <= '0;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ---------------- seven-segment display ----------------
   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
         4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
         4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
         4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
      endcase
   endfunction

   for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib
      assign nib[gi] = ssg_q[4*gi +: 4];
   end

   always_comb begin
      dig_d = dig_q;
      if (scan_cnt_q == SCW'(SCAN_DIV - 1))
         dig_d = (dig_q == DIGW'(NDIG - 1)) ? '0 : dig_q + 1'b1;
   end

   // Select and segments are registered from the next digit index so both change together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scan_cnt_q <= '0;
         dig_q      <= '0;
         ssgs_q     <= ~NDIG'(1);
         ssgd_q     <= 8'hC0;
      end else begin
         scan_cnt_q <= (scan_cnt_q == SCW'(SCAN_DIV - 1)) ? '0 : scan_cnt_q + 1'b1;
         dig_q      <= dig_d;
         ssgs_q     <= ~(NDIG'(1) << dig_d);
         ssgd_q     <= seg7(nib[dig_d]);
      end
   end

   assign do_o   = do_q;
   assign rdy_o  = rdy_q;
   assign tx_o   = tx_q;
   assign led_o  = led_q;
   assign ssgd_o = ssgd_q;
   assign ssgs_o = ssgs_q;

endmodule

// File: tb/tb_io_ctl_gen.sv
// Testbench for io_ctl_gen: register table vectors, randomized register traffic against
// a behavioural register model, UART waveform/receiver checks and display scan checks.
module tb_io_ctl_gen;
   localparam int LED_W = 8;
   localparam int SW_W  = 8;
   localparam int NDIG  = 4;
   localparam int DEPTH = 8;
   localparam int BDRST = 868;
   localparam int SCAN  = 4;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       din_i = '0, addr_i = '0;
   logic              we_i = 1'b0, rreq_i = 1'b0;
   logic [31:0]       do_o;
   logic              rdy_o, tx_o;
   logic [SW_W-1:0]   sw_i = '0;
   logic [LED_W-1:0]  led_o;
   logic [7:0]        ssgd_o;
   logic [NDIG-1:0]   ssgs_o;

   io_ctl_gen #(.LED_W(LED_W), .SW_W(SW_W), .NDIG(NDIG), .FIFO_DEPTH(DEPTH),
                .BAUD_DIV_RST(BDRST), .SCAN_DIV(SCAN), .BASE(BASE)) dut (
      .clk_i(clk), .rst_ni(rst_n), .din_i(din_i), .addr_i(addr_i), .we_i(we_i),
      .rreq_i(rreq_i), .do_o(do_o), .rdy_o(rdy_o), .tx_o(tx_o), .sw_i(sw_i),
      .led_o(led_o), .ssgd_o(ssgd_o), .ssgs_o(ssgs_o));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // clock edges since reset release, for the display scan model
   int kcnt = 0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) kcnt <= 0; else kcnt <= kcnt + 1;

   // serial receiver, samples mid-bit
   logic       rx_en = 1'b0;
   int         rx_div = 16;
   int         rx_ferr = 0;
   logic [7:0] rxq[$];
   initial begin : rx
      logic [9:0] f;
      forever begin
         @(negedge clk);
         if (rx_en && tx_o === 1'b0) begin
            for (int j = 0; j < 10; j++) begin
               repeat ((j == 0) ? rx_div / 2 : rx_div) @(negedge clk);
               f[j] = tx_o;
            end
            rxq.push_back(f[8:1]);
            if (f[0] !== 1'b0 || f[9] !== 1'b1) rx_ferr++;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic fail_timeout(input string nm);
      n_chk++;
      n_err++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   task automatic bus_op(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic rk);
      @(negedge clk);
      we_i = we; rreq_i = re; addr_i = a; din_i = d;
      @(negedge clk);
      rd = do_o; rk = rdy_o;
      we_i = 1'b0; rreq_i = 1'b0;
   endtask

   task automatic op_chk(input string nm, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
      logic [31:0] rd;
      logic        rk;
      bus_op(we, re, a, d, rd, rk);
      chk({nm, "_rdy"}, {31'b0, rk}, 32'd1);
      chk(nm, rd, exp);
      $display("op %s we=%0b re=%0b addr=%08h din=%08h do=%08h", nm, we, re, a, d, rd);
   endtask

   // Waits for a start bit, then checks every cycle of one 8N1 frame.
   task automatic check_frame(input string nm, input int div, input logic [7:0] b);
      int t = 0;
      int bad = 0;
      logic e;
      while (tx_o !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
      if (t >= 4000) begin fail_timeout(nm); return; end
      for (int i = 0; i < 10 * div; i++) begin
         if (i < div)          e = 1'b0;
         else if (i < 9 * div) e = b[(i - div) / div];
         else                  e = 1'b1;
         if (tx_o !== e) bad++;
         @(negedge clk);
      end
      chk({nm, "_badcycles"}, 32'(bad), 32'd0);
      $display("frame %s byte=%02h div=%0d bad=%0d", nm, b, div, bad);
   endtask

   function automatic logic [7:0] seg_ref(input logic [3:0] n);
      logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return tbl[n];
   endfunction

   // behavioural register model
   logic [31:0] m_led, m_ssg, m_div, m_sw;
   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a[31:8] != BASE[31:8]) return 32'd0;
      case (a[7:0])
         8'h00: return m_led;
         8'h04: return m_sw;
         8'h08: return m_ssg;
         8'h0C: return 32'h0000_0100;
         8'h10: return m_div;
         default: return 32'd0;
      endcase
   endfunction

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   initial begin
      vec_t        vt [20];
      logic [31:0] rd;
      logic        rk;
      logic [7:0]  sent [DEPTH + 2];
      int          t;
      int          badb;

      // ---------- reset state ----------
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'b0, tx_o}, 32'd1);
      chk("rst_rdy", {31'b0, rdy_o}, 32'd0);
      chk("rst_do", do_o, 32'd0);
      chk("rst_led", {24'b0, led_o}, 32'd0);
      chk("rst_ssgs", {28'b0, ssgs_o}, 32'hE);
      chk("rst_ssgd", {24'b0, ssgd_o}, 32'hC0);
      rst_n = 1'b1;

      // ---------- table vectors ----------
      vt[0]  = '{1'b1, 1'b0, BASE + 32'h00, 32'h0000_00A5, 32'h0};
      vt[1]  = '{1'b0, 1'b1, BASE + 32'h00, 32'h0,         32'h0000_00A5};
      vt[2]  = '{1'b0, 1'b1, BASE + 32'h40, 32'h0,         32'h0};
      vt[3]  = '{1'b1, 1'b1, BASE + 32'h00, 32'h0000_003C, 32'h0};
      vt[4]  = '{1'b0, 1'b1, BASE + 32'h00, 32'h0,         32'h0000_003C};
      vt[5]  = '{1'b1, 1'b0, BASE + 32'h04, 32'h0000_00FF, 32'h0};
      vt[6]  = '{1'b0, 1'b1, BASE + 32'h04, 32'h0,         32'h0};
      vt[7]  = '{1'b1, 1'b0, BASE + 32'h100, 32'h0000_0077, 32'h0};
      vt[8]  = '{1'b0, 1'b1, BASE + 32'h00, 32'h0,         32'h0000_003C};
      vt[9]  = '{1'b0, 1'b1, BASE + 32'h100, 32'h0,        32'h0};
      vt[10] = '{1'b0, 1'b1, BASE + 32'h10, 32'h0,         32'd868};
      vt[11] = '{1'b1, 1'b0, BASE + 32'h10, 32'h0,         32'h0};
      vt[12] = '{1'b0, 1'b1, BASE + 32'h10, 32'h0,         32'h2};
      vt[13] = '{1'b1, 1'b0, BASE + 32'h10, 32'h1,         32'h0};
      vt[14] = '{1'b0, 1'b1, BASE + 32'h10, 32'h0,         32'h2};
      vt[15] = '{1'b1, 1'b0, BASE + 32'h10, 32'h0001_2345, 32'h0};
      vt[16] = '{1'b0, 1'b1, BASE + 32'h10, 32'h0,         32'h2345};
      vt[17] = '{1'b1, 1'b0, BASE + 32'h08, 32'hFFFF_1234, 32'h0};
      vt[18] = '{1'b0, 1'b1, BASE + 32'h08, 32'h0,         32'h1234};
      vt[19] = '{1'b0, 1'b1, BASE + 32'h0C, 32'h0,         32'h0000_0100};
      for (int i = 0; i < 20; i++)
         op_chk($sformatf("vec%0d", i), vt[i].we, vt[i].re, vt[i].addr, vt[i].din, vt[i].exp);
      chk("led_pin", {24'b0, led_o}, 32'h3C);

      // ---------- switch synchroniser: two back-to-back reads still see the old value ----------
      @(negedge clk);
      sw_i = 8'h3C; rreq_i = 1'b1; addr_i = BASE + 32'h04;
      @(negedge clk); chk("sw_lag1", do_o, 32'h0); chk("sw_b2b_rdy1", {31'b0, rdy_o}, 32'd1);
      @(negedge clk); chk("sw_lag2", do_o, 32'h0); chk("sw_b2b_rdy2", {31'b0, rdy_o}, 32'd1);
      @(negedge clk); chk("sw_sync", do_o, 32'h3C);
      rreq_i = 1'b0;
      @(negedge clk); chk("idle_rdy", {31'b0, rdy_o}, 32'd0); chk("idle_do", do_o, 32'd0);

      // ---------- randomized register traffic ----------
      m_led = 32'h3C; m_ssg = 32'h1234; m_div = 32'h2345; m_sw = 32'h3C;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a, d, e;
         logic        we, re;
         if (i % 10 == 0) begin
            @(negedge clk);
            sw_i = 8'($urandom);
            m_sw = {24'b0, sw_i};
            repeat (3) @(negedge clk);
         end
         case ($urandom_range(0, 7))
            0: a = BASE + 32'h00;
            1: a = BASE + 32'h04;
            2: a = BASE + 32'h08;
            3: a = BASE + 32'h0C;
            4: a = BASE + 32'h10;
            5: a = BASE + 32'h14;
            6: a = BASE + 32'h40;
            default: a = 32'h4000_0000 | (32'($urandom_range(0, 4)) << 2);
         endcase
         we = 1'($urandom_range(0, 1));
         re = we ? 1'($urandom_range(0, 1)) : 1'b1;
         if (a == BASE + 32'h0C) begin we = 1'b0; re = 1'b1; end
         d = $urandom;
         if (d[3]) d[15:0] = 16'($urandom_range(0, 3));
         e = (re && !we) ? model_rd(a) : 32'd0;
         if (we && a[31:8] == BASE[31:8]) begin
            if (a[7:0] == 8'h00) m_led = d & 32'hFF;
            if (a[7:0] == 8'h08) m_ssg = d & 32'hFFFF;
            if (a[7:0] == 8'h10) m_div = (d[15:0] < 16'd2) ? 32'd2 : {16'b0, d[15:0]};
         end
         op_chk($sformatf("rnd%0d", i), we, re, a, d, e);
         @(negedge clk);
         chk("rnd_idle_rdy", {31'b0, rdy_o}, 32'd0);
         chk("rnd_idle_do", do_o, 32'd0);
      end
      chk("rnd_led_pin", {24'b0, led_o}, m_led);

      // ---------- UART frame shape, divisor 4 ----------
      op_chk("div4", 1'b1, 1'b0, BASE + 32'h10, 32'd4, 32'd0);
      op_chk("push55", 1'b1, 1'b0, BASE + 32'h0C, 32'h55, 32'd0);
      check_frame("f55", 4, 8'h55);
      op_chk("push_a3", 1'b1, 1'b0, BASE + 32'h0C, 32'hA3, 32'd0);
      check_frame("fa3", 4, 8'hA3);

      // ---------- burst overflow, divisor 16 ----------
      op_chk("div16", 1'b1, 1'b0, BASE + 32'h10, 32'd16, 32'd0);
      repeat (3) @(negedge clk);
      rxq.delete(); rx_ferr = 0; rx_div = 16; rx_en = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         sent[i] = 8'($urandom);
         @(negedge clk);
         if (i > 0) chk("burst_rdy", {31'b0, rdy_o}, 32'd1);
         we_i = 1'b1; addr_i = BASE + 32'h0C; din_i = {24'b0, sent[i]};
      end
      @(negedge clk);
      chk("burst_rdy_last", {31'b0, rdy_o}, 32'd1);
      we_i = 1'b0;
      op_chk("stat_ovf", 1'b0, 1'b1, BASE + 32'h0C, 32'd0, 32'h8000_0200 | DEPTH);
      op_chk("stat_clr", 1'b0, 1'b1, BASE + 32'h0C, 32'd0, 32'h0000_0200 | DEPTH);
      t = 0;
      while (rxq.size() < DEPTH + 1 && t < (DEPTH + 4) * 11 * 16) begin @(negedge clk); t++; end
      if (t >= (DEPTH + 4) * 11 * 16) fail_timeout("burst_frames");
      repeat (3 * 10 * 16) @(negedge clk);
      rx_en = 1'b0;
      chk("burst_nframes", 32'(rxq.size()), 32'(DEPTH + 1));
      badb = 0;
      for (int i = 0; i < DEPTH + 1 && i < rxq.size(); i++)
         if (rxq[i] !== sent[i]) badb++;
      chk("burst_bytes", 32'(badb), 32'd0);
      chk("burst_framing", 32'(rx_ferr), 32'd0);
      op_chk("stat_drained", 1'b0, 1'b1, BASE + 32'h0C, 32'd0, 32'h0000_0100);

      // ---------- reset mid-transmission ----------
      op_chk("div4b", 1'b1, 1'b0, BASE + 32'h10, 32'd4, 32'd0);
      op_chk("push55b", 1'b1, 1'b0, BASE + 32'h0C, 32'h55, 32'd0);
      t = 0;
      while (tx_o !== 1'b0 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) fail_timeout("rst_mid_start");
      repeat (10) @(negedge clk);
      chk("mid_bit1", {31'b0, tx_o}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", {31'b0, tx_o}, 32'd1);
      chk("mid_rst_led", {24'b0, led_o}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      op_chk("post_stat", 1'b0, 1'b1, BASE + 32'h0C, 32'd0, 32'h0000_0100);
      op_chk("post_led", 1'b0, 1'b1, BASE + 32'h00, 32'd0, 32'd0);
      op_chk("post_div", 1'b0, 1'b1, BASE + 32'h10, 32'd0, 32'd868);
      op_chk("post_ssg", 1'b0, 1'b1, BASE + 32'h08, 32'd0, 32'd0);
      chk("post_tx", {31'b0, tx_o}, 32'd1);

      // ---------- display scan ----------
      op_chk("ssg_wr", 1'b1, 1'b0, BASE + 32'h08, 32'h0000_1F2A, 32'd0);
      @(negedge clk); @(negedge clk);
      for (int i = 0; i < 24; i++) begin
         int          dg;
         logic [15:0] v;
         v  = 16'h1F2A;
         dg = (kcnt / SCAN) % NDIG;
         chk("scan_ssgs", {28'b0, ssgs_o}, {28'b0, ~(4'b0001 << dg)});
         chk("scan_ssgd", {24'b0, ssgd_o}, {24'b0, seg_ref(v[4*dg +: 4])});
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
